// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: turns level-held CPU rd/wr strobes into one Avalon-MM transaction and stalls the CPU until it completes.
// Optional abort timer: define CPU_MEM_BRIDGE_TIMEOUT_EN.
module cpu_mem_bridge #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_rd,
    input  logic              i_cpu_wr,
    input  logic [DATA_W-1:0] i_cpu_wrdata,
    output logic [DATA_W-1:0] o_cpu_rddata,
    output logic              o_cpu_stall,
    output logic              o_cpu_done,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_read,
    output logic              o_avm_write,
    output logic [DATA_W-1:0] o_avm_writedata,
    input  logic [DATA_W-1:0] i_avm_readdata,
    input  logic              i_avm_readdatavalid,
    input  logic              i_avm_waitrequest,
    output logic              o_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wrdata;
    logic [DATA_W-1:0] r_rddata;
    logic              r_err;
    logic              w_req;
    logic              w_busy;
    logic              w_accept;
    logic              w_finish;
    logic              w_timeout;
    logic              w_abort;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cpu_mem_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    assign w_req    = i_cpu_rd | i_cpu_wr;
    assign w_busy   = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_accept = (r_state == S_REQ) && !i_avm_waitrequest;
    // A legitimate completion wins over an abort landing on the same cycle.
    assign w_finish = (w_accept && (r_op_wr || i_avm_readdatavalid)) ||
                      ((r_state == S_WAIT) && i_avm_readdatavalid);
    assign w_abort  = w_timeout && !w_finish;

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 8) ? 8 : ((CNT_W_RAW > 16) ? 16 : CNT_W_RAW);

    logic [CNT_W-1:0] r_cnt;

    // Counts cycles spent in REQ+WAIT; held at zero otherwise so it is clear on REQ entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = w_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = S_REQ;
            S_REQ: begin
                if (w_finish || w_abort) begin
                    w_next = S_DONE;
                end else if (w_accept) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: if (w_finish || w_abort) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_cpu_stall = 1'b0;
        o_cpu_done  = 1'b0;
        o_avm_read  = 1'b0;
        o_avm_write = 1'b0;
        case (r_state)
            S_IDLE: o_cpu_stall = w_req;
            S_REQ: begin
                o_cpu_stall = 1'b1;
                o_avm_write = r_op_wr;
                o_avm_read  = !r_op_wr;
            end
            S_WAIT: o_cpu_stall = 1'b1;
            S_DONE: o_cpu_done = 1'b1;
            default: o_cpu_stall = 1'b0;
        endcase
    end

    // Command latch; simultaneous rd+wr resolves to a write and flags an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_wr  <= 1'b0;
            r_addr   <= '0;
            r_wrdata <= '0;
        end else if ((r_state == S_IDLE) && w_req) begin
            r_op_wr  <= i_cpu_wr;
            r_addr   <= i_cpu_addr;
            r_wrdata <= i_cpu_wrdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rddata <= '0;
        end else if (w_finish && !r_op_wr) begin
            r_rddata <= i_avm_readdata;
        end else if (w_abort && !r_op_wr) begin
            r_rddata <= DATA_W'(16'hDEAD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (((r_state == S_IDLE) && i_cpu_rd && i_cpu_wr) || w_abort) begin
            r_err <= 1'b1;
        end
    end

    assign o_cpu_rddata    = r_rddata;
    assign o_avm_address   = r_addr;
    assign o_avm_writedata = r_wrdata;
    assign o_err           = r_err;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: directed scenarios plus randomized transactions against a transaction-level model.
module tb_cpu_mem_bridge;

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
    localparam int TO       = 4;
    localparam int MAX_BUSY = 3;
`else
    localparam int TO       = 255;
    localparam int MAX_BUSY = 8;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] i_cpu_addr = '0;
    logic        i_cpu_rd = 1'b0;
    logic        i_cpu_wr = 1'b0;
    logic [15:0] i_cpu_wrdata = '0;
    logic [15:0] o_cpu_rddata;
    logic        o_cpu_stall;
    logic        o_cpu_done;
    logic [15:0] o_avm_address;
    logic        o_avm_read;
    logic        o_avm_write;
    logic [15:0] o_avm_writedata;
    logic [15:0] i_avm_readdata = '0;
    logic        i_avm_readdatavalid = 1'b0;
    logic        i_avm_waitrequest = 1'b0;
    logic        o_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc_ctr = 0;

    logic [15:0] m_rddata = '0;
    logic        m_err = 1'b0;

    cpu_mem_bridge #(
        .ADDR_W(16),
        .DATA_W(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_cpu_addr(i_cpu_addr),
        .i_cpu_rd(i_cpu_rd),
        .i_cpu_wr(i_cpu_wr),
        .i_cpu_wrdata(i_cpu_wrdata),
        .o_cpu_rddata(o_cpu_rddata),
        .o_cpu_stall(o_cpu_stall),
        .o_cpu_done(o_cpu_done),
        .o_avm_address(o_avm_address),
        .o_avm_read(o_avm_read),
        .o_avm_write(o_avm_write),
        .o_avm_writedata(o_avm_writedata),
        .i_avm_readdata(i_avm_readdata),
        .i_avm_readdatavalid(i_avm_readdatavalid),
        .i_avm_waitrequest(i_avm_waitrequest),
        .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    // One CPU transaction; the bus holds waitrequest for w strobe cycles and returns read data l cycles after accept.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdat, input int w, input int l, input bit idle_after);
        int  nstrobe, acc_at, stall_cnt, busy, exp_stall;
        bit  finished, is_rd, timed_out;
        is_rd     = rd && !wr;
        busy      = w + 1 + (is_rd ? l : 0);
        timed_out = (busy > TO);
        exp_stall = timed_out ? 1 + TO : 1 + busy;
        if (rd && wr) m_err = 1'b1;
        if (timed_out) m_err = 1'b1;
        if (is_rd) m_rddata = timed_out ? 16'hDEAD : rdat;
        nstrobe = 0; acc_at = -1; stall_cnt = 0; finished = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            i_cpu_rd = rd; i_cpu_wr = wr; i_cpu_addr = addr; i_cpu_wrdata = wdata;
            i_avm_waitrequest = 1'b1; i_avm_readdatavalid = 1'b0; i_avm_readdata = 16'($urandom);
            if (o_avm_read || o_avm_write) begin
                if (nstrobe >= w) begin
                    i_avm_waitrequest = 1'b0;
                    if (acc_at < 0) acc_at = cyc;
                end
                nstrobe++;
            end
            if (is_rd && acc_at >= 0 && (cyc - acc_at) == l) begin
                i_avm_readdatavalid = 1'b1;
                i_avm_readdata = rdat;
            end
            @(negedge clk);
            if (o_cpu_stall) stall_cnt++;
            if (o_avm_read || o_avm_write) begin
                vectors++;
                if ({o_avm_read, o_avm_write, o_avm_address, o_avm_writedata} !== {is_rd, !is_rd, addr, wdata}) begin
                    miscompares++;
                    $display("FAIL bus_cmd: got rd=%0b wr=%0b a=%h d=%h, want rd=%0b wr=%0b a=%h d=%h",
                             o_avm_read, o_avm_write, o_avm_address, o_avm_writedata, is_rd, !is_rd, addr, wdata);
                end
            end
            if (o_cpu_done) begin
                finished = 1'b1;
                break;
            end
            next_drive();
        end
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL done_timeout: no done pulse within 64 cycles (addr=%h)", addr);
        end else begin
            vectors++;
            if (stall_cnt != exp_stall) begin
                miscompares++;
                $display("FAIL stall_cycles: got %0d, want %0d (w=%0d l=%0d rd=%0b)", stall_cnt, exp_stall, w, l, is_rd);
            end
            vectors++;
            if (o_cpu_rddata !== m_rddata || o_err !== m_err) begin
                miscompares++;
                $display("FAIL done_state: got rddata=%h err=%0b, want rddata=%h err=%0b",
                         o_cpu_rddata, o_err, m_rddata, m_err);
            end
            if (!timed_out) begin
                vectors++;
                if (nstrobe != w + 1) begin
                    miscompares++;
                    $display("FAIL strobe_cycles: got %0d, want %0d", nstrobe, w + 1);
                end
            end
        end
        next_drive();
        i_cpu_rd = 1'b0; i_cpu_wr = 1'b0;
        i_avm_readdatavalid = 1'b0; i_avm_waitrequest = 1'b0;
        if (idle_after) begin
            i_avm_readdatavalid = 1'($urandom_range(0, 1));
            i_avm_readdata = 16'($urandom);
            @(negedge clk);
            vectors++;
            if ({o_cpu_done, o_cpu_stall, o_avm_read, o_avm_write} !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle_after_done: got done=%0b stall=%0b rd=%0b wr=%0b, want all 0",
                         o_cpu_done, o_cpu_stall, o_avm_read, o_avm_write);
            end
            next_drive();
            i_avm_readdatavalid = 1'b0;
            @(negedge clk);
            vectors++;
            if (o_cpu_rddata !== m_rddata) begin
                miscompares++;
                $display("FAIL stray_rdv: got rddata=%h, want %h", o_cpu_rddata, m_rddata);
            end
            next_drive();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        vectors++;
        if ({o_cpu_rddata, o_cpu_stall, o_cpu_done, o_avm_address, o_avm_read, o_avm_write, o_avm_writedata, o_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rddata=%h stall=%0b done=%0b addr=%h rd=%0b wr=%0b wd=%h err=%0b, want all 0",
                     o_cpu_rddata, o_cpu_stall, o_cpu_done, o_avm_address, o_avm_read, o_avm_write, o_avm_writedata, o_err);
        end
        next_drive();
        reset = 1'b1;
        next_drive();
    endtask

    task automatic test_write_basic();
        run_txn(1'b0, 1'b1, 16'h0040, 16'h1234, 16'h0000, 0, 0, 1'b1);
    endtask

    task automatic test_read_wait();
        run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 3, 2, 1'b1);
    endtask

    task automatic test_read_same_cycle();
        run_txn(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h00A5, 0, 0, 1'b1);
    endtask

    task automatic test_reset_midflight();
        i_cpu_rd = 1'b1; i_cpu_addr = 16'h0100; i_avm_waitrequest = 1'b1;
        next_drive();
        @(negedge clk);
        vectors++;
        if (o_avm_read !== 1'b1) begin
            miscompares++;
            $display("FAIL midflight_req: got avm_read=%0b, want 1", o_avm_read);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (o_avm_read !== 1'b0) begin
            miscompares++;
            $display("FAIL async_drop: got avm_read=%0b, want 0", o_avm_read);
        end
        i_cpu_rd = 1'b0; i_avm_waitrequest = 1'b0;
        m_rddata = '0; m_err = 1'b0;
        next_drive();
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({o_cpu_stall, o_cpu_rddata, o_err, o_avm_address} !== {1'b0, 16'h0000, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL post_reset: got stall=%0b rddata=%h err=%0b addr=%h, want 0 0000 0 0000",
                     o_cpu_stall, o_cpu_rddata, o_err, o_avm_address);
        end
        next_drive();
    endtask

    task automatic test_rd_wr_conflict();
        run_txn(1'b1, 1'b1, 16'h0300, 16'h5A5A, 16'h0000, 1, 0, 1'b1);
        run_txn(1'b1, 1'b0, 16'h0302, 16'h0000, 16'h1111, 0, 1, 1'b1);
    endtask

    task automatic test_timeout();
`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 16'h0400, 16'h0000, 16'h7777, 1000, 0, 1'b1);
`endif
    endtask

    task automatic test_back_to_back();
        int start;
        start = cyc_ctr;
        run_txn(1'b0, 1'b1, 16'h0500, 16'hAAAA, 16'h0000, 0, 0, 1'b0);
        run_txn(1'b0, 1'b1, 16'h0502, 16'hBBBB, 16'h0000, 0, 0, 1'b0);
        run_txn(1'b0, 1'b1, 16'h0504, 16'hCCCC, 16'h0000, 0, 0, 1'b0);
        vectors++;
        if (cyc_ctr - start != 9) begin
            miscompares++;
            $display("FAIL b2b_throughput: got %0d cycles for 3 writes, want 9", cyc_ctr - start);
        end
    endtask

    task automatic test_random();
        int sel, w, l;
        logic rd, wr;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel >= 4);
            wr  = (sel < 4) || (sel == 9);
            w   = $urandom_range(0, MAX_BUSY - 1);
            l   = $urandom_range(0, MAX_BUSY - 1 - w);
            run_txn(rd, wr, 16'($urandom), 16'($urandom), 16'($urandom), w, l, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_read_same_cycle();
        test_reset_midflight();
        test_rd_wr_conflict();
        test_timeout();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
Sits directly downstream of the 16-bit CPU memory port, between the CPU and an Avalon-MM style memory/peripheral fabric that has variable latency.
Converts the CPU's level-held rd/wr strobes into one handshaked bus transaction. It stalls the CPU until the transaction completes.
Captures read data into a holding register so the CPU sees stable data on the completion cycle.

Parameters:
ADDR_W, 16, address width on both sides
DATA_W, 16, data width on both sides
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before abort (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
i_cpu_addr  input  ADDR_W  CPU address, passed through unchanged
i_cpu_rd  input  1  CPU read request, held until o_cpu_stall low
i_cpu_wr  input  1  CPU write request, held until o_cpu_stall low
i_cpu_wrdata  input  DATA_W  CPU write data
o_cpu_rddata  output  DATA_W  read holding register
o_cpu_stall  output  1  CPU must hold its state and request while high
o_cpu_done  output  1  one-cycle completion pulse
o_avm_address  output  ADDR_W  bus address (latched)
o_avm_read  output  1  bus read strobe
o_avm_write  output  1  bus write strobe
o_avm_writedata  output  DATA_W  bus write data (latched)
i_avm_readdata  input  DATA_W  bus read data
i_avm_readdatavalid  input  1  read data valid
i_avm_waitrequest  input  1  bus not accepting the command this cycle
o_err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; latched address/data 0.
  - Any transaction in flight is abandoned. Strobes drop immediately, without waiting for a clock edge.
- States: IDLE, REQ, WAIT, DONE (registered state).
- IDLE:
  - If i_cpu_wr or i_cpu_rd: latch addr, wrdata and the op, then go to REQ.
  - o_cpu_stall = (i_cpu_rd | i_cpu_wr), combinational, in the same cycle.
  - rd and wr both high: write wins, read is dropped, o_err set.
- REQ:
  - o_avm_read or o_avm_write asserted, with address/data driven from the latches; o_cpu_stall=1.
  - Hold while i_avm_waitrequest=1.
  - When waitrequest=0 on a write: go to DONE.
  - When waitrequest=0 on a read with readdatavalid=1 in the same cycle: capture readdata and go to DONE.
  - When waitrequest=0 on a read with readdatavalid=0: go to WAIT.
- WAIT:
  - Strobes deasserted; o_cpu_stall=1.
  - On readdatavalid=1: capture readdata into o_cpu_rddata and go to DONE.
  - readdatavalid in any state other than REQ or WAIT is ignored.
- DONE:
  - o_cpu_stall=0 and o_cpu_done=1 for exactly one cycle, then IDLE.
  - New requests are not sampled in DONE. The earliest new command is accepted in IDLE on the next cycle.
- Latency and throughput:
  - Minimum latency with zero-wait write is IDLE, REQ, DONE: the CPU is stalled 2 cycles.
  - Throughput is at most one transaction per 3 cycles.
- o_cpu_rddata:
  - Updates only on read capture.
  - Writes leave it unchanged; it holds its value indefinitely.
- o_err: sticky, cleared only by reset.
- Address and data are passed through unmodified; there is no alignment check.

Optional Feature:
- Macro CPU_MEM_BRIDGE_TIMEOUT_EN.
- Enabled:
  - An 8..16-bit counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES: strobes drop, o_cpu_rddata is loaded with 16'hDEAD for reads, o_err is set, and the state goes to DONE.
  - Late readdatavalid after the abort is ignored.
- Disabled: no counter; the bridge waits forever.

Test Plan:
1. reset=0 asserted mid-REQ with waitrequest=1 -> o_avm_read=0 with no clock edge; after release, stall=0 and rddata=0.
2. Write, addr=16'h0040, data=16'h1234, waitrequest=0 -> write strobe 1 cycle with those values, stall for 2 cycles, done pulse, rddata unchanged.
3. Read, addr=16'h0100, waitrequest=1 for 3 cycles, readdatavalid 2 cycles after accept with 16'hBEEF -> rddata=16'hBEEF at the done pulse; stall for 7 cycles.
4. Read with waitrequest=0 and readdatavalid=1 in the same cycle (16'h00A5) -> IDLE, REQ, DONE; rddata=16'h00A5.
5. rd=1 and wr=1 together -> only o_avm_write issued, o_err=1 and stays 1 after a subsequent clean read.
6. With the timeout macro enabled, TIMEOUT_CYCLES=4, read with waitrequest stuck at 1 -> abort after 4 cycles, rddata=16'hDEAD, o_err=1, done pulse.
